// File: rtl/traffic_phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
//   Shared types and constants for the two-road traffic phase sequencer.
//   - state_t : the seven phases (WALK is only reachable when the pedestrian
//               request feature PED_REQUEST_EN is compiled in)
//   - light_t : {red,yellow,green} lamp encoding, exactly one bit set
//   - CNT_W   : width of the per-phase countdown shown on the display
//   - ns_light_of / ew_light_of : lamp pattern of each road for a phase
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam int CNT_W   = 4;
    localparam int MAX_SEC = 10;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_A     = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_B     = 3'd5,
        WALK      = 3'd6
    } state_t;

    typedef logic [2:0] light_t;

    localparam light_t LIGHT_RED    = 3'b100;
    localparam light_t LIGHT_YELLOW = 3'b010;
    localparam light_t LIGHT_GREEN  = 3'b001;

    // North-south lamps: only the two NS phases show anything but red.
    function automatic light_t ns_light_of(state_t s);
        case (s)
            NS_GREEN:  return LIGHT_GREEN;
            NS_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    // East-west lamps: only the two EW phases show anything but red.
    function automatic light_t ew_light_of(state_t s);
        case (s)
            EW_GREEN:  return LIGHT_GREEN;
            EW_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer_if
//   Bundles the sequencer's lamp, countdown and pedestrian signals.
//   master : sequencer side (drives lamps/countdown, reads ped_req)
//   slave  : board side (reads lamps/countdown, drives ped_req)
//   Signals:
//     ns_light, ew_light  {red,yellow,green} per road
//     counter             ticks left in the current phase (1..10)
//     phase_done          one-clk pulse on the cycle the phase changes
//     ped_req, walk       only present with PED_REQUEST_EN defined
//   Handshake: none; all sequencer outputs are plain registered levels/pulses
//   and ped_req is an asynchronous level sampled by a synchroniser.
// ---------------------------------------------------------------------------
interface traffic_phase_sequencer_if;
    import traffic_pkg::*;

    light_t           ns_light;
    light_t           ew_light;
    logic [CNT_W-1:0] counter;
    logic             phase_done;
`ifdef PED_REQUEST_EN
    logic             ped_req;
    logic             walk;

    modport master (output ns_light, ew_light, counter, phase_done, walk,
                    input  ped_req);
    modport slave  (input  ns_light, ew_light, counter, phase_done, walk,
                    output ped_req);
`else
    modport master (output ns_light, ew_light, counter, phase_done);
    modport slave  (input  ns_light, ew_light, counter, phase_done);
`endif

endinterface

// File: rtl/traffic_phase_sequencer_second_tick_gen.sv
// ---------------------------------------------------------------------------
// second_tick_gen
//   Prescaler producing the countdown tick. Counts 0..TICK_DIV-1 and raises
//   tick for the single cycle in which it sits at TICK_DIV-1, so the first
//   tick is consumed on the TICK_DIV-th clock edge after reset release.
//   Ports:
//     clk   in  board clock
//     reset in  asynchronous, active-high reset (clears the prescaler)
//     tick  out one-clk tick pulse
// ---------------------------------------------------------------------------
module second_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("second_tick_gen: TICK_DIV must be at least 2");
    end

    logic [PW-1:0] presc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (presc_q == LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + ONE;
        end
    end

    assign tick = (presc_q == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//   Steps a two-road intersection through
//   NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> ...
//   one countdown tick at a time, showing ticks remaining on `counter`.
//   Optional feature macro: PED_REQUEST_EN
//     A synchronised rising edge on ped_req latches a sticky request; the
//     next yellow exit then enters WALK (both roads red, walk=1) instead of
//     the all-red clearance, and WALK resumes at the green that red led to.
//   Ports:
//     clk       in  board clock
//     reset     in  asynchronous, active-high reset
//     lights    if  traffic_phase_sequencer_if.master (lamps, counter,
//                   phase_done, and ped_req/walk with PED_REQUEST_EN)
//     dbg_state out current phase register
//   All interface outputs are registers loaded from the next-state logic, so
//   lamps, counter and phase_done move together on one clock edge.
// ---------------------------------------------------------------------------
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int GREEN_SEC  = 9,
    parameter int YELLOW_SEC = 3,
    parameter int RED_SEC    = 2,
    parameter int WALK_SEC   = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_sequencer_if.master   lights,
    output state_t                      dbg_state
);

    if ((GREEN_SEC  < 1) || (GREEN_SEC  > MAX_SEC) ||
        (YELLOW_SEC < 1) || (YELLOW_SEC > MAX_SEC) ||
        (RED_SEC    < 1) || (RED_SEC    > MAX_SEC) ||
        (WALK_SEC   < 1) || (WALK_SEC   > MAX_SEC)) begin : g_bad_duration
        $error("traffic_phase_sequencer: phase durations must lie in 1..10");
    end

    localparam logic [CNT_W-1:0] GREEN_CNT  = CNT_W'(GREEN_SEC);
    localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_SEC);
    localparam logic [CNT_W-1:0] RED_CNT    = CNT_W'(RED_SEC);
    localparam logic [CNT_W-1:0] WALK_CNT   = CNT_W'(WALK_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Duration loaded into the countdown on entry to a phase.
    function automatic logic [CNT_W-1:0] dur_of(state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return GREEN_CNT;
            NS_YELLOW, EW_YELLOW: return YELLOW_CNT;
            WALK:                 return WALK_CNT;
            default:              return RED_CNT;
        endcase
    endfunction

    logic tick;

    second_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_t           state_q, state_d, succ;
    logic             state_legal;
    logic [CNT_W-1:0] counter_q, counter_d;
    light_t           ns_q, ew_q;
    logic             done_q, done_d;

`ifdef PED_REQUEST_EN
    // ped_sync_q[1:0] is the two-flop synchroniser; [2] holds the previous
    // synchronised level for rising-edge detection.
    logic [2:0] ped_sync_q;
    logic       ped_rise;
    logic       ped_pending_q, ped_pending_d;
    logic       walk_to_ew_q;
    logic       entering_walk;
    logic       walk_q;

    assign ped_rise      = ped_sync_q[1] & ~ped_sync_q[2];
    assign entering_walk = (state_d == WALK) && (state_q != WALK);
`endif

    // Next phase, countdown and phase_done.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        done_d      = 1'b0;
        state_legal = 1'b1;
        succ        = state_q;

        case (state_q)
            NS_GREEN:  succ = NS_YELLOW;
            NS_YELLOW: succ = RED_A;
            RED_A:     succ = EW_GREEN;
            EW_GREEN:  succ = EW_YELLOW;
            EW_YELLOW: succ = RED_B;
            RED_B:     succ = NS_GREEN;
`ifdef PED_REQUEST_EN
            WALK:      succ = walk_to_ew_q ? EW_GREEN : NS_GREEN;
`endif
            default:   state_legal = 1'b0;
        endcase

`ifdef PED_REQUEST_EN
        // A pending request replaces the all-red clearance after a yellow.
        if (ped_pending_q && ((state_q == NS_YELLOW) || (state_q == EW_YELLOW))) begin
            succ = WALK;
        end
`endif

        if (!state_legal) begin
            // Corrupted state register: fall back to a safe all-red phase.
            state_d   = RED_A;
            counter_d = RED_CNT;
            done_d    = 1'b1;
        end else if (tick) begin
            if (counter_q > CNT_ONE) begin
                counter_d = counter_q - CNT_ONE;
            end else begin
                state_d   = succ;
                counter_d = dur_of(succ);
                done_d    = 1'b1;
            end
        end
    end

`ifdef PED_REQUEST_EN
    // Request latch: cleared when WALK is entered, ignores presses in WALK.
    always_comb begin
        ped_pending_d = ped_pending_q;
        if (entering_walk) begin
            ped_pending_d = 1'b0;
        end else if (ped_rise && (state_q != WALK)) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_sync_q    <= '0;
            ped_pending_q <= 1'b0;
            walk_to_ew_q  <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            ped_sync_q    <= {ped_sync_q[1:0], lights.ped_req};
            ped_pending_q <= ped_pending_d;
            walk_q        <= (state_d == WALK);
            if (entering_walk) begin
                // WALK replaced RED_A after NS_YELLOW, so it hands over to EW.
                walk_to_ew_q <= (state_q == NS_YELLOW);
            end
        end
    end

    assign lights.walk = walk_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= NS_GREEN;
            counter_q <= GREEN_CNT;
            ns_q      <= LIGHT_GREEN;
            ew_q      <= LIGHT_RED;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            ns_q      <= ns_light_of(state_d);
            ew_q      <= ew_light_of(state_d);
            done_q    <= done_d;
        end
    end

    assign lights.ns_light   = ns_q;
    assign lights.ew_light   = ew_q;
    assign lights.counter    = counter_q;
    assign lights.phase_done = done_q;
    assign dbg_state         = state_q;

endmodule
